// File: rtl/readout_scheduler_pkg.sv
// Shared definitions for the readout scheduler: FSM state encoding,
// settings-register offsets relative to BASE_ADDR, and ctrl bit positions.
package readout_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READ  = 3'd2,
    ST_GAP   = 3'd3,
    ST_FLUSH = 3'd4
  } sched_state_e;

  localparam logic [7:0] REG_FRAME_LEN = 8'd0;
  localparam logic [7:0] REG_GAP_LEN   = 8'd1;
  localparam logic [7:0] REG_CTRL      = 8'd2;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_OVF_CLR_BIT = 1;

endpackage

// File: rtl/readout_scheduler_setting_reg.sv
// One address-decoded settings register.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   set_stb_i/addr_i/data_i  settings-bus write
//   val_o                    register value (low WIDTH bits of the write data)
//   changed_o                one-cycle pulse in the cycle after a write to ADDR
module sched_setting_reg #(
  parameter logic [7:0] ADDR  = 8'd0,
  parameter int         WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_stb_i,
  input  logic [7:0]       set_addr_i,
  input  logic [31:0]      set_data_i,
  output logic [WIDTH-1:0] val_o,
  output logic             changed_o
);

  logic             wr_hit;
  logic [WIDTH-1:0] val_q;
  logic             changed_q;
  logic             unused_data;

  assign wr_hit      = set_stb_i && (set_addr_i == ADDR);
  // Upper data bits are ignored by narrow registers.
  assign unused_data = ^set_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= wr_hit;
      if (wr_hit) begin
        val_q <= set_data_i[WIDTH-1:0];
      end
    end
  end

  assign val_o     = val_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/readout_scheduler.sv
// Readout scheduler: paces reads of FFT bins out of a FIFO into frames of
// frame_len bins, with an optional gap_len idle cycles between bins.
// Flushes the FIFO and raises a sticky overflow flag when the FFT core
// writes into a full FIFO.
// Ports:
//   clock, reset                   clock, asynchronous active-low reset
//   set_stb/set_addr/set_data      settings bus (frame_len, gap_len, ctrl)
//   wr_en_in, fifo_full            monitored FIFO write side (overflow detect)
//   fifo_empty, fifo_rd_en         FIFO read handshake
//   dv_out, sof_out, eof_out       output word qualifiers, aligned to FIFO dout
//   overflow, busy                 status
//   frame_count                    only with READOUT_SCHED_STATS_EN defined
// Configuration macro: READOUT_SCHED_STATS_EN adds the frame_count output.
module readout_scheduler
  import readout_scheduler_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'd1,
  parameter int         CNT_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        wr_en_in,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        dv_out,
  output logic        sof_out,
  output logic        eof_out,
  output logic        overflow,
  output logic        busy
`ifdef READOUT_SCHED_STATS_EN
  ,
  output logic [31:0] frame_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       rst_sync_q;
  logic             run_ok;

  logic [CNT_W-1:0] frame_len_q;
  logic [CNT_W-1:0] gap_len_q;
  logic [1:0]       ctrl_q;
  logic             ctrl_chg;
  logic             unused_frame_chg;
  logic             unused_gap_chg;

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] frame_sh_q, frame_sh_d;
  logic [CNT_W-1:0] gap_sh_q, gap_sh_d;

  logic             rd_en;
  logic             dv_d, sof_d, eof_d;
  logic             dv_q, sof_q, eof_q;
  logic             last_bin;
  logic             ovf_set, ovf_clr;
  logic             overflow_q;

  // Reset release is synchronised; the FSM may only leave IDLE once both
  // flops have seen reset deasserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign run_ok = rst_sync_q[1];

  sched_setting_reg #(.ADDR(BASE_ADDR + REG_FRAME_LEN), .WIDTH(CNT_W)) u_frame_len (
    .clk_i(clock), .rst_ni(reset), .set_stb_i(set_stb), .set_addr_i(set_addr),
    .set_data_i(set_data), .val_o(frame_len_q), .changed_o(unused_frame_chg)
  );

  sched_setting_reg #(.ADDR(BASE_ADDR + REG_GAP_LEN), .WIDTH(CNT_W)) u_gap_len (
    .clk_i(clock), .rst_ni(reset), .set_stb_i(set_stb), .set_addr_i(set_addr),
    .set_data_i(set_data), .val_o(gap_len_q), .changed_o(unused_gap_chg)
  );

  sched_setting_reg #(.ADDR(BASE_ADDR + REG_CTRL), .WIDTH(2)) u_ctrl (
    .clk_i(clock), .rst_ni(reset), .set_stb_i(set_stb), .set_addr_i(set_addr),
    .set_data_i(set_data), .val_o(ctrl_q), .changed_o(ctrl_chg)
  );

  // The overflow clear acts only in the single cycle after a ctrl write with
  // bit1 set, so the stored bit1 never needs to be cleared by software.
  assign ovf_clr  = ctrl_chg && ctrl_q[CTRL_OVF_CLR_BIT];
  assign ovf_set  = wr_en_in && fifo_full;
  assign last_bin = (bin_cnt_q == frame_sh_q - CNT_ONE);

  always_comb begin
    state_d    = state_q;
    bin_cnt_d  = bin_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    frame_sh_d = frame_sh_q;
    gap_sh_d   = gap_sh_q;
    rd_en      = 1'b0;
    dv_d       = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bin_cnt_d = '0;
        // Lengths are shadowed here so mid-frame writes wait for the next frame.
        if (run_ok && ctrl_q[CTRL_EN_BIT] && (frame_len_q != '0)) begin
          state_d    = ST_WAIT;
          frame_sh_d = frame_len_q;
          gap_sh_d   = gap_len_q;
        end
      end
      ST_WAIT: begin
        if (!fifo_empty) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Back-to-back reads can drain the FIFO; an empty FIFO here sends us
        // back to WAIT without consuming a bin.
        if (fifo_empty) begin
          state_d = ST_WAIT;
        end else begin
          rd_en = 1'b1;
          dv_d  = 1'b1;
          sof_d = (bin_cnt_q == '0);
          eof_d = last_bin;
          if (last_bin) begin
            state_d   = ST_IDLE;
            bin_cnt_d = '0;
          end else begin
            bin_cnt_d = bin_cnt_q + CNT_ONE;
            if (gap_sh_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == gap_sh_q - CNT_ONE) begin
          state_d = fifo_empty ? ST_WAIT : ST_READ;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
      end
      ST_FLUSH: begin
        bin_cnt_d = '0;
        if (fifo_empty) begin
          state_d = ST_IDLE;
        end else begin
          rd_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Overflow preempts everything: the frame in flight is abandoned and any
    // word read this cycle is discarded.
    if (ovf_set) begin
      state_d   = ST_FLUSH;
      bin_cnt_d = '0;
      dv_d      = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bin_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      frame_sh_q <= '0;
      gap_sh_q   <= '0;
    end else begin
      state_q    <= state_d;
      bin_cnt_q  <= bin_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      frame_sh_q <= frame_sh_d;
      gap_sh_q   <= gap_sh_d;
    end
  end

  // Output stage: one cycle behind the read, matching FIFO read latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dv_q       <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dv_q  <= dv_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign fifo_rd_en = rd_en;
  assign dv_out     = dv_q;
  assign sof_out    = sof_q;
  assign eof_out    = eof_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef READOUT_SCHED_STATS_EN
  logic [31:0] frame_count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
    end else if (ovf_clr) begin
      frame_count_q <= '0;
    end else if (eof_q) begin
      frame_count_q <= frame_count_q + 32'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_readout_scheduler.sv
module tb_readout_scheduler;

  localparam logic [7:0] A_FRAME = 8'd1;
  localparam logic [7:0] A_GAP   = 8'd2;
  localparam logic [7:0] A_CTRL  = 8'd3;

  logic        clock;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        wr_en_in;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        dv_out;
  logic        sof_out;
  logic        eof_out;
  logic        overflow;
  logic        busy;
`ifdef READOUT_SCHED_STATS_EN
  logic [31:0] frame_count;
`endif

  typedef struct {
    logic sof;
    logic eof;
    int   gap;   // cycles since previous dv_out, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   fifo_cnt = 0;
  int   add_n = 0;
  int   cyc = 0;
  int   last_dv = 0;

  readout_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .wr_en_in   (wr_en_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .dv_out     (dv_out),
    .sof_out    (sof_out),
    .eof_out    (eof_out),
    .overflow   (overflow),
    .busy       (busy)
`ifdef READOUT_SCHED_STATS_EN
    ,
    .frame_count(frame_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO occupancy model: words added by the bench, removed by DUT reads.
  always @(posedge clock) begin
    fifo_cnt <= fifo_cnt + add_n - (fifo_rd_en ? 1 : 0);
  end
  assign fifo_empty = (fifo_cnt == 0);

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(logic [7:0] a, logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(posedge clock);
    #1;
    set_stb  = 1'b0;
  endtask

  task automatic push(int n);
    add_n = n;
    @(posedge clock);
    #1;
    add_n = 0;
  endtask

  task automatic exp_bin(logic s, logic f, int g);
    exp_t x;
    x.sof = s;
    x.eof = f;
    x.gap = g;
    exp_q.push_back(x);
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    @(negedge clock);
    while (busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk(name, busy, 1'b0);
    cycles(2);
  endtask

  // Monitor: pops one expected bin per dv_out and checks flags and spacing.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL rd_en_while_empty got rd_en=1 expected 0 at cycle %0d", cyc);
        end
      end
      if (!dv_out && (sof_out || eof_out)) begin
        checks++;
        errors++;
        $display("FAIL flag_without_dv got sof=%0b eof=%0b expected 0", sof_out, eof_out);
      end
      if (dv_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dv got sof=%0b eof=%0b expected no output", sof_out, eof_out);
        end else begin
          e = exp_q.pop_front();
          if (sof_out !== e.sof || eof_out !== e.eof || (e.gap >= 0 && (cyc - last_dv) != e.gap)) begin
            errors++;
            $display("FAIL bin got sof=%0b eof=%0b gap=%0d expected sof=%0b eof=%0b gap=%0d",
                     sof_out, eof_out, cyc - last_dv, e.sof, e.eof, e.gap);
          end
        end
        last_dv = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    wr_en_in = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_dv", dv_out, 0);
    chk("rst_sof", sof_out, 0);
    chk("rst_eof", eof_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
`ifdef READOUT_SCHED_STATS_EN
    chk("rst_frame_count", frame_count, 0);
`endif
    @(posedge clock);
    #1 reset = 1'b1;
    cycles(4);

    // Two back-to-back frames of 4 bins, no gap.
    push(8);
    wr(A_FRAME, 4);
    wr(A_GAP, 0);
    exp_bin(1, 0, -1); exp_bin(0, 0, 1); exp_bin(0, 0, 1); exp_bin(0, 1, 1);
    exp_bin(1, 0, 3);  exp_bin(0, 0, 1); exp_bin(0, 0, 1); exp_bin(0, 1, 1);
    wr(A_CTRL, 1);
    cycles(8);
    wr(A_CTRL, 0);
    wait_idle("t1_idle");

    // 3 bins with gap 2: outputs 3 cycles apart. Enable dropped mid-frame.
    push(3);
    wr(A_FRAME, 3);
    wr(A_GAP, 2);
    exp_bin(1, 0, -1); exp_bin(0, 0, 3); exp_bin(0, 1, 3);
    wr(A_CTRL, 1);
    wr(A_CTRL, 0);
    wait_idle("t2_idle");

    // Single-bin frame: sof and eof together.
    push(1);
    wr(A_FRAME, 1);
    wr(A_GAP, 0);
    exp_bin(1, 1, -1);
    wr(A_CTRL, 1);
    wr(A_CTRL, 0);
    wait_idle("t2b_idle");

    // FIFO runs dry after 2 of 4 bins; scheduler parks in WAIT.
    push(2);
    wr(A_FRAME, 4);
    exp_bin(1, 0, -1); exp_bin(0, 0, 1);
    wr(A_CTRL, 1);
    wr(A_CTRL, 0);
    cycles(6);
    chk("t3_wait_busy", busy, 1);
    chk("t3_wait_no_rd", fifo_rd_en, 0);
    exp_bin(0, 0, -1); exp_bin(0, 1, 1);
    push(2);
    wait_idle("t3_idle");

    // Overflow mid-frame: flush with no output, sticky flag, clear, set-wins.
    push(4);
    wr(A_FRAME, 4);
    wr(A_GAP, 2);
    exp_bin(1, 0, -1);
    wr(A_CTRL, 1);
    wr(A_CTRL, 0);
    cycles(2);
    wr_en_in = 1'b1; fifo_full = 1'b1;
    cycles(1);
    wr_en_in = 1'b0; fifo_full = 1'b0;
    chk("t4_ovf_set", overflow, 1);
    chk("t4_flush_busy", busy, 1);
    wait_idle("t4_idle");
    chk("t4_drained", fifo_cnt, 0);
    chk("t4_ovf_sticky", overflow, 1);
    wr(A_CTRL, 2);
    cycles(2);
    chk("t4_ovf_clear", overflow, 0);
    wr(A_CTRL, 2);
    wr_en_in = 1'b1; fifo_full = 1'b1;
    cycles(1);
    wr_en_in = 1'b0; fifo_full = 1'b0;
    cycles(1);
    chk("t4_set_wins", overflow, 1);
    wait_idle("t4_idle2");
    wr(A_CTRL, 2);
    cycles(2);
    chk("t4_ovf_clear2", overflow, 0);

`ifdef READOUT_SCHED_STATS_EN
    // Three single-bin frames counted, then cleared.
    chk("st_start", frame_count, 0);
    push(3);
    wr(A_FRAME, 1);
    wr(A_GAP, 0);
    exp_bin(1, 1, -1); exp_bin(1, 1, 3); exp_bin(1, 1, 3);
    wr(A_CTRL, 1);
    cycles(7);
    wr(A_CTRL, 0);
    wait_idle("st_idle");
    chk("st_count3", frame_count, 3);
    wr(A_CTRL, 2);
    cycles(2);
    chk("st_cleared", frame_count, 0);
`endif

    // Asynchronous reset while reading.
    push(4);
    wr(A_FRAME, 4);
    wr(A_GAP, 0);
    wr(A_CTRL, 1);
    cycles(3);
    chk("t5_reading", fifo_rd_en, 1);
    chk("t5_dv_before", dv_out, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rd_en", fifo_rd_en, 0);
    chk("t5_dv", dv_out, 0);
    chk("t5_sof", sof_out, 0);
    chk("t5_eof", eof_out, 0);
    chk("t5_busy", busy, 0);
    chk("t5_overflow", overflow, 0);
    cycles(2);
    reset = 1'b1;
    cycles(4);
    // frame_len was cleared by reset, so enable alone must not start a frame.
    wr(A_CTRL, 1);
    cycles(5);
    chk("t5_len0_idle", busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/readout_scheduler.md
READOUT_SCHEDULER -- requirements
Module: readout_scheduler

Interface
REQ-001 Parameter BASE_ADDR, default 8'd1: settings-bus address of register 0 (frame_len); registers 1 (gap_len) and 2 (ctrl) follow at BASE_ADDR+1 and BASE_ADDR+2.
REQ-002 Parameter CNT_W, default 16: width of the bin and gap counters.
REQ-003 Ports SHALL be exactly:
clock  in  1  sole clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
set_stb  in  1  settings-bus write strobe
set_addr  in  8  settings-bus address
set_data  in  32  settings-bus data
wr_en_in  in  1  FFT-core data-valid into the FIFO (monitored only)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO read enable
dv_out  out  1  output word valid, aligned with FIFO dout (1-cycle read latency)
sof_out  out  1  with dv_out: first bin of a frame
eof_out  out  1  with dv_out: last bin of a frame
overflow  out  1  sticky: write attempted while FIFO full
busy  out  1  FSM not in IDLE

Function
REQ-010 Register writes: set_stb=1 and set_addr matching -> register loads set_data[CNT_W-1:0] (ctrl: bits[1:0]) on the next edge.
REQ-011 ctrl bit0 = enable; ctrl bit1 = overflow clear, self-clearing one cycle after the write.
REQ-012 FSM states: IDLE, WAIT, READ, GAP, FLUSH.
REQ-013 IDLE -> WAIT when enable=1 and frame_len!=0; frame_len=0 keeps the FSM in IDLE.
REQ-014 WAIT -> READ when fifo_empty=0.
REQ-015 READ: fifo_rd_en=1 for exactly one cycle; bin_cnt increments; next state GAP if gap_len!=0, else READ (if not empty) or WAIT (if empty).
REQ-016 GAP: lasts exactly gap_len cycles, then READ if not empty, else WAIT.
REQ-017 After bin frame_len-1 is read -> IDLE; bin_cnt clears; next frame starts on the next qualifying cycle.
REQ-018 fifo_rd_en SHALL never assert while fifo_empty=1.
REQ-019 dv_out = fifo_rd_en registered one cycle; sof_out/eof_out registered with the same one-cycle delay for bin 0 / bin frame_len-1.
REQ-020 frame_len=1: sof_out and eof_out assert on the same dv_out cycle.
REQ-021 wr_en_in=1 and fifo_full=1 in the same cycle -> overflow=1 next cycle; FSM enters FLUSH from any state.
REQ-022 FLUSH: fifo_rd_en=1 whenever not empty, dv_out held 0; empty -> IDLE with bin_cnt cleared.
REQ-023 overflow clears only on a ctrl bit1 write; a set event in the same cycle as a clear wins (stays 1).
REQ-024 enable deasserted mid-frame: current frame completes, then IDLE.
REQ-025 frame_len/gap_len writes mid-frame take effect at the next IDLE->WAIT transition (shadow latched there).

Reset
REQ-030 reset=0 asynchronously forces IDLE, counters 0, frame_len=0, gap_len=0, ctrl=0, and all outputs 0.
REQ-031 Deassertion is synchronised internally (two-flop release) before the FSM leaves IDLE.

Configuration
REQ-040 Macro READOUT_SCHED_STATS_EN defined: adds output frame_count[31:0], incremented on each eof_out, wrapping at 2^32-1->0, cleared by reset and by a ctrl bit1 write.
REQ-041 Macro undefined: no frame_count port or logic; all other behaviour identical.

Structure
REQ-050 Shared package holds the FSM state encoding, the register offsets (0,1,2), and the ctrl bit indices.
REQ-051 One sub-module, sched_setting_reg: one address-decoded settings register with a changed pulse, instantiated three times.

Verification
REQ-060 frame_len=4, gap_len=0, FIFO preloaded with 8 words, enable -> 4 consecutive dv_out; sof on the 1st, eof on the 4th; second frame follows with sof.
REQ-061 frame_len=3, gap_len=2 -> dv_out pulses spaced exactly 3 cycles apart.
REQ-062 FIFO empties after 2 of 4 bins -> FSM waits in WAIT with no fifo_rd_en; resumes on refill; eof on the 4th bin.
REQ-063 wr_en_in=1 with fifo_full=1 mid-frame -> overflow=1 next cycle, FIFO drained with dv_out=0, then IDLE; ctrl=3 write clears overflow.
REQ-064 reset=0 asserted mid-READ -> all outputs 0 in the same cycle with no clock edge; FSM returns to IDLE.
REQ-065 With READOUT_SCHED_STATS_EN defined: 3 frames -> frame_count=3; ctrl bit1 write -> 0.
